dac_sample_sequencer: RTL and testbench
=======================================

Name: dac_sample_sequencer

Overview:
- Parametrised, buffered sample path from the RISC-V core to one or more 10-bit DAC channels. It generalises the single direct core-to-DAC connection.
- The core pushes tagged samples (data + channel index) through a valid/ready handshake into a FIFO.
- The block pops samples at a programmable rate and drives per-channel holding registers feeding the DACs.
- Underflow and bad-channel conditions are reported.

Parameters:
- DW, 10, sample width in bits per DAC channel
- NUM_CH, 2, number of DAC channels (1..16)
- CHW, 4, channel-index width (must satisfy 2^CHW >= NUM_CH)
- DEPTH, 8, FIFO entries (power of two, >= 2)
- DIVW, 16, rate-divider width

Ports:
- clk  input  1  system clock (PLL output)
- reset  input  1  asynchronous, active-high reset
- in_data  input  DW  sample value from core
- in_ch  input  CHW  target channel index
- in_valid  input  1  sample valid
- in_ready  output  1  FIFO can accept; equals !full
- enable  input  1  playback enable
- div  input  DIVW  rate divider; a pop opportunity occurs every div+1 cycles
- clr_flags  input  1  clears sticky flags
- dac_out  output  NUM_CH*DW  channel holding registers; channel k occupies bits [k*DW +: DW]
- dac_update  output  NUM_CH  one-cycle strobe per channel on register update
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- underflow  output  1  sticky flag: a tick occurred with FIFO empty
- bad_ch  output  1  sticky flag: a popped sample had in_ch >= NUM_CH

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, dac_out=0, dac_update=0, underflow=0, bad_ch=0, rate counter=0. in_ready=1 (combinational, !full).
- Push:
  - occurs when in_valid && in_ready; {in_ch,in_data} written at the write pointer.
  - When full, in_ready=0 even if a pop occurs in the same cycle (no bypass).
- Rate counter:
  - runs only while enable=1; when enable=0 it is held at 0.
  - tick = enable && (cnt == div); on tick cnt←0, else cnt←cnt+1.
  - div=0 → tick every enabled cycle.
  - If div changes while running and cnt > new div: cnt continues up and wraps at 2^DIVW. No protection is required; software changes div only while enable=0.
- Pop:
  - On tick with registered fifo_level > 0: pop head entry.
  - Same-cycle push into an empty FIFO is not poppable until the next cycle.
- Output update:
  - Popped entry with ch < NUM_CH: dac_out[ch] ← data and dac_update[ch]=1 on the next edge (one cycle after the pop decision). Other channels hold.
  - Popped entry with ch >= NUM_CH: discarded; bad_ch←1; no dac_update.
- Underflow: tick with FIFO empty → underflow←1; all dac_out hold their values.
- Flag clear: clr_flags=1 clears underflow and bad_ch. If set and clear occur in the same cycle, set wins.
- Occupancy:
  - fifo_level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
  - Pointers wrap modulo DEPTH.
- Minimum latency: push at edge t into empty FIFO with div=0 → pop at t+1 → dac_out/dac_update visible after edge t+2.
- Reset mid-operation: FIFO contents discarded, outputs return to reset values immediately (asynchronous).
- enable drop: no pops from the next cycle; FIFO contents and dac_out retained.

Test Plan:
- Reset then enable=1, div=0, push (ch0,0x155), (ch1,0x2AA) on consecutive cycles → dac_out ch0=0x155 at cycle t+2, ch1=0x2AA at t+3; single-cycle dac_update pulses 01 then 10; fifo_level returns to 0.
- enable=0, push 9 samples with DEPTH=8 → in_ready drops after 8 accepts; fifo_level=8; 9th held until enable=1, then accepted after the first pop.
- div=3, FIFO preloaded with 4 samples → updates exactly every 4 cycles; after the last, the next tick sets underflow=1 while dac_out holds the last value; clr_flags clears it.
- Push (ch=5,0x3FF) with NUM_CH=2 → no dac_update, dac_out unchanged, bad_ch=1; clr_flags asserted on the same cycle as a new bad pop → bad_ch stays 1.
- Assert reset asynchronously with fifo_level=5 mid-playback → all outputs 0 immediately; in_ready=1; no dac_update after release until new pushes arrive.
- Sustained push and pop at div=0 with full FIFO → fifo_level stable, and values on dac_out match push order (scoreboard over 1000 random samples and channels).

Source files
------------

// File: rtl/dac_sample_sequencer.sv
// -----------------------------------------------------------------------------
// dac_sample_sequencer
//
// Buffered sample path from the core to NUM_CH DAC channels. The core pushes
// tagged samples {channel, data} into a FIFO. A programmable rate counter
// produces pop opportunities ("ticks"). Each popped sample is written into the
// holding register of its channel one cycle later.
//
// Handshake (in_valid / in_ready): a sample is transferred on every rising
// clock edge where in_valid && in_ready are both high. in_ready depends only on
// registered occupancy (it is !full), never on in_valid. A pop in the same
// cycle does not make room for a push into a full FIFO.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   in_data     sample value from the core
//   in_ch       target channel index of the sample
//   in_valid    sample valid
//   in_ready    FIFO can accept a sample (== !full)
//   enable      playback enable; the rate counter is held at 0 while low
//   div         rate divider; one tick every div+1 enabled cycles
//   clr_flags   clears the sticky flags (a set in the same cycle wins)
//   dac_out     channel holding registers, channel k at [k*DW +: DW]
//   dac_update  one-cycle strobe per channel when its register is written
//   fifo_level  current FIFO occupancy
//   underflow   sticky: a tick happened while the FIFO was empty
//   bad_ch      sticky: a popped sample carried a channel index >= NUM_CH
// -----------------------------------------------------------------------------
module dac_sample_sequencer #(
  parameter int DW     = 10,
  parameter int NUM_CH = 2,
  parameter int CHW    = 4,
  parameter int DEPTH  = 8,
  parameter int DIVW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            in_data,
  input  logic [CHW-1:0]           in_ch,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic [DIVW-1:0]          div,
  input  logic                     clr_flags,
  output logic [NUM_CH*DW-1:0]     dac_out,
  output logic [NUM_CH-1:0]        dac_update,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow,
  output logic                     bad_ch
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CHW + DW;

  // One extra bit so NUM_CH == 2**CHW still compares correctly.
  localparam logic [CHW:0]  CH_LIMIT  = (CHW+1)'(NUM_CH);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------------
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            tick;

  logic [DIVW-1:0] cnt;

  // Pop stage: the entry taken from the FIFO, applied to the DACs next edge.
  logic            pop_valid;
  logic [CHW-1:0]  pop_ch;
  logic [DW-1:0]   pop_data;
  logic            pop_ch_ok;

  assign full      = (fifo_level == LEVEL_MAX);
  assign empty     = (fifo_level == '0);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;

  // Pop uses the registered level, so a sample pushed into an empty FIFO
  // becomes poppable only in the following cycle.
  assign tick      = enable && (cnt == div);
  assign pop       = tick && !empty;

  assign pop_ch_ok = ({1'b0, pop_ch} < CH_LIMIT);

  // Storage has no reset: contents are meaningless while fifo_level is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_ch, in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rate counter. Held at 0 while disabled so the first tick after enable
  // arrives div+1 cycles later. A div lowered below cnt while running lets cnt
  // run up and wrap; software only changes div while disabled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pop stage register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_valid <= 1'b0;
      pop_ch    <= '0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop;
      if (pop) begin
        {pop_ch, pop_data} <= mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel holding registers and update strobes. Only the addressed channel
  // changes; an out-of-range channel updates nothing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dac_out    <= '0;
      dac_update <= '0;
    end else begin
      dac_update <= '0;
      if (pop_valid && pop_ch_ok) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (pop_ch == CHW'(k)) begin
            dac_out[k*DW +: DW] <= pop_data;
            dac_update[k]       <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as clr_flags takes priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (tick && empty) begin
      underflow <= 1'b1;
    end else if (clr_flags) begin
      underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_ch <= 1'b0;
    end else if (pop_valid && !pop_ch_ok) begin
      bad_ch <= 1'b1;
    end else if (clr_flags) begin
      bad_ch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_sequencer
//
// Directed bench for dac_sample_sequencer with default parameters
// (DW=10, NUM_CH=2, CHW=4, DEPTH=8, DIVW=16). Inputs change 1 time unit after
// a rising edge; outputs are checked at the same point, reflecting that edge.
// -----------------------------------------------------------------------------
module tb_dac_sample_sequencer;

  localparam int DW     = 10;
  localparam int NUM_CH = 2;
  localparam int CHW    = 4;
  localparam int DEPTH  = 8;
  localparam int DIVW   = 16;
  localparam int N_RAND = 1000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                   clk = 1'b0;
  logic                   reset;
  logic [DW-1:0]          in_data;
  logic [CHW-1:0]         in_ch;
  logic                   in_valid;
  logic                   in_ready;
  logic                   enable;
  logic [DIVW-1:0]        div;
  logic                   clr_flags;
  logic [NUM_CH*DW-1:0]   dac_out;
  logic [NUM_CH-1:0]      dac_update;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   underflow;
  logic                   bad_ch;

  always #5 clk = ~clk;

  dac_sample_sequencer #(
    .DW(DW), .NUM_CH(NUM_CH), .CHW(CHW), .DEPTH(DEPTH), .DIVW(DIVW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_ch(in_ch),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .enable(enable),
    .div(div),
    .clr_flags(clr_flags),
    .dac_out(dac_out),
    .dac_update(dac_update),
    .fifo_level(fifo_level),
    .underflow(underflow),
    .bad_ch(bad_ch)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [CHW+DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [CHW-1:0] ch, input logic [DW-1:0] d);
    in_ch    = ch;
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic              will_push;
    logic [CHW+DW-1:0] entry;
    int                e_ch;
    int                sent;
    int                got;

    reset     = 1'b1;
    in_data   = '0;
    in_ch     = '0;
    in_valid  = 1'b0;
    enable    = 1'b0;
    div       = '0;
    clr_flags = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_dac_out",    dac_out,    32'h0);
    chk("rst_dac_update", dac_update, 32'h0);
    chk("rst_level",      fifo_level, 32'h0);
    chk("rst_underflow",  underflow,  32'h0);
    chk("rst_bad_ch",     bad_ch,     32'h0);
    chk("rst_in_ready",   in_ready,   32'h1);
    reset = 1'b0;
    step();

    // T1: minimum latency, two channels, div=0
    enable   = 1'b1;
    div      = '0;
    in_ch    = 4'd0;
    in_data  = 10'h155;
    in_valid = 1'b1;
    step();                                 // push ch0 (FIFO was empty)
    in_ch    = 4'd1;
    in_data  = 10'h2AA;
    step();                                 // pop ch0, push ch1
    in_valid = 1'b0;
    chk("t1_out_t1",   dac_out,    32'h0);
    chk("t1_level_t1", fifo_level, 32'h1);
    step();                                 // ch0 visible at t+2
    chk("t1_out_t2",   dac_out,    32'h00155);
    chk("t1_upd_t2",   dac_update, 32'h1);
    chk("t1_level_t2", fifo_level, 32'h0);
    step();                                 // ch1 visible at t+3
    chk("t1_out_t3",   dac_out,    32'hAA955);
    chk("t1_upd_t3",   dac_update, 32'h2);
    step();
    chk("t1_upd_t4",   dac_update, 32'h0);
    chk("t1_unf_set",  underflow,  32'h1);
    enable = 1'b0;
    clear_flags();
    chk("t1_unf_clr",  underflow,  32'h0);

    // T2: fill with playback disabled, 9th sample waits for the first pop
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_ready_fill", in_ready, 32'h1);
      push1(CHW'(i % 2), DW'(16 + i));
    end
    chk("t2_level_full", fifo_level, 32'h8);
    chk("t2_ready_full", in_ready,   32'h0);
    in_ch    = 4'd0;
    in_data  = 10'h018;
    in_valid = 1'b1;
    step();
    chk("t2_level_held", fifo_level, 32'h8);
    enable = 1'b1;
    step();                                 // pop only, push blocked (no bypass)
    chk("t2_level_pop",  fifo_level, 32'h7);
    chk("t2_ready_pop",  in_ready,   32'h1);
    step();                                 // push 9th + pop
    in_valid = 1'b0;
    chk("t2_level_pp",   fifo_level, 32'h7);
    chk("t2_upd_first",  dac_update, 32'h1);
    chk("t2_out_first",  dac_out,    32'hAA810);
    repeat (8) step();
    chk("t2_level_drn",  fifo_level, 32'h0);
    chk("t2_out_drn",    dac_out,    32'h05C18);
    chk("t2_unf_drn",    underflow,  32'h1);
    enable = 1'b0;
    clear_flags();
    chk("t2_unf_clr",    underflow,  32'h0);

    // T3: div=3 with four preloaded samples, then underflow on empty tick
    push1(4'd0, 10'h101);
    push1(4'd1, 10'h102);
    push1(4'd0, 10'h103);
    push1(4'd1, 10'h104);
    chk("t3_level", fifo_level, 32'h4);
    div    = 16'd3;
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      logic [31:0] exp_upd;
      step();
      if (k == 5 || k == 13)      exp_upd = 32'h1;
      else if (k == 9 || k == 17) exp_upd = 32'h2;
      else                        exp_upd = 32'h0;
      chk("t3_upd", dac_update, exp_upd);
      chk("t3_unf", underflow,  (k >= 20) ? 32'h1 : 32'h0);
    end
    chk("t3_out_hold", dac_out, 32'h41103);
    enable = 1'b0;
    clear_flags();
    chk("t3_unf_clr",  underflow, 32'h0);

    // T4: out-of-range channels; clear collides with a new bad pop
    div = '0;
    push1(4'd5, 10'h3FF);
    push1(4'd7, 10'h3FF);
    enable = 1'b1;
    step();                                 // pop first bad sample
    chk("t4_bad_lat", bad_ch, 32'h0);
    step();                                 // flag set, pop second bad sample
    chk("t4_bad_set", bad_ch,     32'h1);
    chk("t4_upd",     dac_update, 32'h0);
    chk("t4_out",     dac_out,    32'h41103);
    enable    = 1'b0;
    clr_flags = 1'b1;
    step();                                 // set and clear together
    chk("t4_bad_win", bad_ch,     32'h1);
    chk("t4_upd2",    dac_update, 32'h0);
    chk("t4_level",   fifo_level, 32'h0);
    step();
    clr_flags = 1'b0;
    chk("t4_bad_clr", bad_ch,     32'h0);
    chk("t4_unf",     underflow,  32'h0);

    // T5: asynchronous reset mid-playback with five queued samples
    for (int i = 0; i < 5; i++) begin
      push1(CHW'(i % 2), DW'(10'h200 + i));
    end
    chk("t5_level_pre", fifo_level, 32'h5);
    div    = 16'd3;
    enable = 1'b1;
    step();
    step();
    chk("t5_level_run", fifo_level, 32'h5);
    #3 reset = 1'b1;
    #1;
    chk("t5_rst_out",   dac_out,    32'h0);
    chk("t5_rst_level", fifo_level, 32'h0);
    chk("t5_rst_ready", in_ready,   32'h1);
    chk("t5_rst_upd",   dac_update, 32'h0);
    chk("t5_rst_unf",   underflow,  32'h0);
    chk("t5_rst_bad",   bad_ch,     32'h0);
    step();
    reset = 1'b0;
    div   = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_post_upd", dac_update, 32'h0);
      chk("t5_post_out", dac_out,    32'h0);
    end
    chk("t5_post_level", fifo_level, 32'h0);

    // T6: sustained push and pop from a full FIFO, scoreboard over N_RAND
    enable = 1'b0;
    div    = '0;
    exp_q.delete();
    sent = 0;
    got  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_ch    = CHW'($urandom_range(0, 1));
      in_data  = DW'($urandom_range(0, 1023));
      in_valid = 1'b1;
      exp_q.push_back({in_ch, in_data});
      sent++;
      step();
    end
    chk("t6_level_full", fifo_level, 32'h8);
    in_ch    = CHW'($urandom_range(0, 1));
    in_data  = DW'($urandom_range(0, 1023));
    in_valid = 1'b1;
    enable   = 1'b1;
    for (int cyc = 0; cyc < 4 * N_RAND && got < N_RAND; cyc++) begin
      will_push = in_valid && in_ready;
      if (will_push) begin
        exp_q.push_back({in_ch, in_data});
        sent++;
      end
      step();
      if (will_push) begin
        chk("t6_level", fifo_level, 32'h7);
        if (sent < N_RAND) begin
          in_ch   = CHW'($urandom_range(0, 1));
          in_data = DW'($urandom_range(0, 1023));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (dac_update != '0) begin
        if (exp_q.size() == 0) begin
          chk("t6_extra_upd", dac_update, 32'h0);
        end else begin
          entry = exp_q.pop_front();
          e_ch  = int'(entry[CHW+DW-1:DW]);
          chk("t6_upd",  dac_update, 32'h1 << e_ch);
          chk("t6_data", dac_out[e_ch*DW +: DW], entry[DW-1:0]);
          got++;
        end
      end
    end
    in_valid = 1'b0;
    chk("t6_count",   got,          N_RAND);
    chk("t6_q_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
